add_recover_serial: RTL
=======================

# add_recover_serial

Bit-serial inverse of the parameterised ripple-carry full adder. Given an adder result `{c_out, sum}`, the addend `b` and the carry-in `c_in`, it recovers the augend `a = {c_out,sum} - b - c_in`. It works one bit per clock with a full-subtractor cell and a start/done handshake. It also flags results that no SIZE-bit `a` could have produced. It sits on the checker side of the adder datapath, next to `full_adder_gen`.

## Interface
Parameters:
- `SIZE`, default 4: operand width; must be ≥ 1.

Ports:
- `clk`, input, 1: sole clock; all state updates on rising edge.
- `rst_n`, input, 1: reset is asynchronous and active-low.
- `start`, input, 1: request; sampled only in IDLE or DONE.
- `sum`, input, SIZE: adder sum to invert.
- `c_out`, input, 1: adder carry-out; forms bit SIZE of the minuend.
- `b`, input, SIZE: addend, used as the subtrahend.
- `c_in`, input, 1: adder carry-in, used as the initial borrow.
- `a`, output, SIZE: recovered augend; valid while `done`=1 and held afterwards.
- `err`, output, 1: inconsistent input (no SIZE-bit `a` exists); valid with `a`.
- `busy`, output, 1: high in RUN.
- `done`, output, 1: one-cycle pulse when the result becomes valid.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN when `start`=1.
  - RUN → DONE when the bit counter reaches SIZE-1.
  - DONE → RUN when `start`=1; otherwise DONE → IDLE.
- Start accepted:
  - Latch minuend register M = `{c_out,sum}` (SIZE+1 bits) and subtrahend register S = `b`.
  - Set borrow register = `c_in`; clear bit counter to 0.
  - The `a` shift register keeps its old contents until overwritten bit by bit.
- Each RUN cycle, with x=M[0], y=S[0], q=borrow:
  - Difference bit d = x^y^q.
  - Borrow-out = (~x&y) | (~x&q) | (y&q).
  - Shift M and S right by one. Shift d into the MSB of `a`, shifting `a` right.
  - Increment the counter.
- After SIZE RUN cycles, `a` holds bits 0..SIZE-1, LSB first in time.
- Error rule, evaluated on the last RUN edge:
  - Top bit T = M's remaining bit (original `c_out`).
  - `err` = T ^ final borrow.
  - `err`=0 only when the (SIZE+1)-bit difference is non-negative and fits SIZE bits.
- On `err`=1, `a` still holds the low SIZE bits of the two's-complement difference, i.e. modulo 2^SIZE.
- `start` is ignored in RUN; no queuing.
- `start` while in DONE begins a new operation on that edge. `done` still pulses for the finished result during that cycle.
- All arithmetic is unsigned, modulo 2^(SIZE+1) internally.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE; `a`=0, `err`=0, `busy`=0, `done`=0; counter, borrow, M and S cleared. Takes effect immediately, including mid-RUN; the in-flight operation is discarded with no `done`.
- Latency: `start` sampled at edge E0; `done`=1 during the cycle following edge E_SIZE, i.e. SIZE clocks after acceptance.
- `busy`=1 from after E0 through E_SIZE; `busy`=0 in DONE.
- `done` lasts exactly one cycle per operation.
- Throughput: back-to-back starts in DONE give one result every SIZE clocks.
- Inputs are sampled only at the accepting edge; changes during RUN have no effect.
- SIZE=1: RUN lasts one cycle; the counter never wraps mid-operation.

## Configuration
- Macro `ADD_RECOVER_ERR_EN`.
- Defined: `err` is computed as above.
- Undefined: `err` is tied to 0 and no top-bit or final-borrow check logic is synthesised. `a` and timing are unchanged.

## Test plan
- SIZE=4; `sum`=15, `c_out`=0, `b`=8, `c_in`=0, pulse `start` → 4 clocks later `done`=1, `a`=7, `err`=0.
- `sum`=5, `c_out`=1, `b`=11, `c_in`=1 → `a`=9, `err`=0.
- Inconsistent input: `sum`=2, `c_out`=0, `b`=5, `c_in`=0 → `a`=13, `err`=1. Overflow: `sum`=15, `c_out`=1, `b`=0, `c_in`=0 → `a`=15, `err`=1. With `ADD_RECOVER_ERR_EN` undefined, both give `err`=0 and the same `a`.
- Protocol:
  - `start` held high through RUN → no restart; `done` pulses once.
  - `start` in DONE with new operands → second `done` exactly 4 clocks later with the correct second result.
  - Change `sum` mid-RUN → result unaffected.
- Reset: assert `rst_n`=0 two clocks into RUN, mid-cycle → outputs 0 immediately and no `done`. Release, then a fresh operation gives the correct result.

Source files
------------

// File: rtl/add_recover_serial.sv
// Bit-serial augend recovery: a = {c_out,sum} - b - c_in, one full-subtractor step per clock.
// Optional consistency flag `err` is built only when ADD_RECOVER_ERR_EN is defined.
module add_recover_serial #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [SIZE-1:0] sum,
    input  logic            c_out,
    input  logic [SIZE-1:0] b,
    input  logic            c_in,
    output logic [SIZE-1:0] a,
    output logic            err,
    output logic            busy,
    output logic            done
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [SIZE:0]   m;
    logic [SIZE-1:0] s;
    logic            borrow;
    logic [CW-1:0]   cnt;

    logic d, bo, last, accept;

    assign d      = m[0] ^ s[0] ^ borrow;
    assign bo     = (~m[0] & s[0]) | (~m[0] & borrow) | (s[0] & borrow);
    assign last   = (cnt == CW'(SIZE - 1));
    assign accept = start && (state == IDLE || state == DONE);

`ifdef ADD_RECOVER_ERR_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            m      <= '0;
            s      <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef ADD_RECOVER_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                state  <= RUN;
                busy   <= 1'b1;
                m      <= {c_out, sum};
                s      <= b;
                borrow <= c_in;
                cnt    <= '0;
            end else begin
                case (state)
                    RUN: begin
                        // Difference bits enter at the MSB so bit 0 ends up LSB after SIZE shifts.
                        a      <= (a >> 1) | (SIZE'(d) << (SIZE - 1));
                        m      <= m >> 1;
                        s      <= s >> 1;
                        borrow <= bo;
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`ifdef ADD_RECOVER_ERR_EN
                            // m[1] is still the original c_out on the last step.
                            err_q <= m[1] ^ bo;
`endif
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
